// File: rtl/mmc_gate_driver.sv
// Half-bridge gate driver for N submodules with per-transition dead time and latched fault; gates move 1 cycle after accept, new side DT_CYCLES later.
// m_ready is low while any leg is off/dead or off target, and stays low once a fault latches; masks offered then are dropped, not buffered.
module mmc_gate_driver #(
  parameter int N         = 12,
  parameter int DT_CYCLES = 20,
  parameter int CW        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:1]   M,
  input  logic         m_valid,
  output logic         m_ready,
  input  logic         fault,
  output logic [N:1]   gate_hi,
  output logic [N:1]   gate_lo,
  output logic [3:0]   insert_count,
  output logic         fault_latched
);

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_BYPASS, S_INSERT} state_t;

  localparam logic [CW-1:0] DT_LOAD = CW'(DT_CYCLES - 1);

  state_t        state_q [N:1];
  state_t        state_d [N:1];
  logic [CW-1:0] cnt_q   [N:1];
  logic [CW-1:0] cnt_d   [N:1];
  logic [N:1]    dest_q, dest_d;      // 1 = leaving DEAD towards INSERT
  logic [N:1]    target_q, target_d;
  logic [N:1]    hi_d, lo_d;
  logic [3:0]    count_d;
  logic          all_settled;
  logic          accept;

  always_comb begin
    all_settled = 1'b1;
    for (int i = 1; i <= N; i++) begin
      if (!((state_q[i] == S_BYPASS && !target_q[i]) ||
            (state_q[i] == S_INSERT &&  target_q[i])))
        all_settled = 1'b0;
    end
    m_ready = !fault_latched && all_settled;
    accept  = m_valid && m_ready && !fault;
  end

  always_comb begin
    target_d = accept ? M : target_q;
    dest_d   = dest_q;
    count_d  = '0;
    hi_d     = '0;
    lo_d     = '0;
    for (int i = 1; i <= N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (fault || fault_latched) begin
        // A latched fault parks every leg with both switches open until reset.
        state_d[i] = S_OFF;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_OFF: begin
            state_d[i] = S_DEAD;
            cnt_d[i]   = DT_LOAD;
            dest_d[i]  = 1'b0;
          end
          S_BYPASS: begin
            if (target_q[i]) begin
              state_d[i] = S_DEAD;
              cnt_d[i]   = DT_LOAD;
              dest_d[i]  = 1'b1;
            end
          end
          S_INSERT: begin
            if (!target_q[i]) begin
              state_d[i] = S_DEAD;
              cnt_d[i]   = DT_LOAD;
              dest_d[i]  = 1'b0;
            end
          end
          default: begin
            if (cnt_q[i] == '0)
              state_d[i] = dest_q[i] ? S_INSERT : S_BYPASS;
            else
              cnt_d[i] = cnt_q[i] - CW'(1);
          end
        endcase
      end
      hi_d[i] = (state_d[i] == S_INSERT);
      lo_d[i] = (state_d[i] == S_BYPASS);
      if (state_q[i] == S_INSERT)
        count_d = count_d + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= N; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      dest_q        <= '0;
      target_q      <= '0;
      gate_hi       <= '0;
      gate_lo       <= '0;
      insert_count  <= '0;
      fault_latched <= 1'b0;
    end else begin
      for (int i = 1; i <= N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      dest_q        <= dest_d;
      target_q      <= target_d;
      gate_hi       <= hi_d;
      gate_lo       <= lo_d;
      insert_count  <= count_d;
      fault_latched <= fault_latched | fault;
    end
  end

endmodule

// File: doc/mmc_gate_driver.md
Name: mmc_gate_driver

Overview:
- Consumer side of the sorter's insertion mask.
- Accepts the 12-bit insert/bypass mask M[12:1] through a valid/ready handshake.
- Drives complementary half-bridge gate pairs for the 12 submodules, with a programmable dead time on every transition.
- Provides a latched fault shutdown and a count of currently inserted submodules; sits between the sorter and the gate-driver I/O.

Parameters:
- N, 12, number of submodules (mask and gate widths).
- DT_CYCLES, 20, dead-time length in clk cycles; legal range 1..255.
- CW, 8, dead-time counter width; must satisfy 2^CW > DT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- M  input  [N:1]  requested mask; 1 = insert submodule, 0 = bypass.
- m_valid  input  1  M is valid this cycle.
- m_ready  output  1  block can accept a new mask.
- fault  input  1  synchronous fault request; level-sensitive, sampled each edge.
- gate_hi  output  [N:1]  upper switch drive (insert path).
- gate_lo  output  [N:1]  lower switch drive (bypass path).
- insert_count  output  4  number of submodules in INSERT state (registered).
- fault_latched  output  1  sticky fault flag.

Behaviour:
- Reset (asynchronous): gate_hi=0, gate_lo=0, m_ready=0, insert_count=0, fault_latched=0, target mask=0, every submodule in OFF.
- Per-submodule FSM: OFF, DEAD, BYPASS, INSERT.
  - OFF -> DEAD on the first edge after rst is deasserted, with destination BYPASS.
  - BYPASS or INSERT -> DEAD when target bit != current side; destination is the target side.
  - DEAD: counter loads DT_CYCLES-1 on entry and decrements each cycle; at 0, moves to the destination on the next edge.
- Gate outputs are registered and derived from state only:
  - BYPASS: gate_lo=1, gate_hi=0.
  - INSERT: gate_hi=1, gate_lo=0.
  - OFF and DEAD: both 0.
  - gate_hi and gate_lo are never both 1 in any cycle.
- m_ready (combinational) = no fault_latched AND no submodule in OFF or DEAD AND target equals the current side for all submodules.
- Handshake: the mask is accepted on an edge where m_valid AND m_ready; the target register loads M.
  - m_valid while m_ready=0 is ignored. No buffering; the source must hold or re-present M.
- Timing for an accept at edge k:
  - Changed bits enter DEAD at edge k+1, so the old gate falls at k+1.
  - The new gate rises at edge k+1+DT_CYCLES.
  - Unchanged bits keep their gate with no glitch.
  - m_ready drops in the cycle after accept (target != state) and returns when all transitions are complete.
- A mask identical to the current state is accepted, causes no transitions, and m_ready stays 1.
- A direction reversal mid-DEAD is impossible: the target cannot change while any module is in DEAD.
- insert_count is the registered popcount of INSERT states, updated the edge after the state changes. Range 0..12; 4-bit width is sufficient.
- Fault:
  - fault=1 at an edge sets fault_latched=1 and forces all submodules to OFF; gates are 0 from that edge, overriding any DEAD in progress.
  - The fault is sticky until rst, and m_ready stays 0.
  - fault has priority over a simultaneous accept; the mask is not loaded.
- Reset asserted mid-transition: all outputs return to reset values immediately, without waiting for clk.
- After reset release, m_ready rises once all modules reach BYPASS, i.e. DT_CYCLES+1 edges after release.

Test Plan:
- Startup, DT_CYCLES=20: release rst -> gate_lo=12'hFFF and gate_hi=0 at edge 21 after release; m_ready=1 from then; insert_count=0.
- Accept M=12'b000000000111 -> bits 1-3 gate_lo falls at k+1, gate_hi rises at k+21; insert_count=3 one edge later; other bits' gate_lo stays 1 throughout.
- From M=12'h007, accept M=12'h00E -> bit1 goes insert->bypass and bit4 goes bypass->insert concurrently; bits 2,3 unchanged; insert_count stays 3 after settling; m_ready low for exactly 21 cycles.
- m_valid held with M=12'hFFF while m_ready=0 (mid-DEAD) -> ignored; accepted on the first edge m_ready=1; final insert_count=12.
- Assert fault for one cycle mid-DEAD -> all gates 0 next edge; fault_latched=1; m_ready=0 persists; only rst clears it.
- Every cycle of all scenarios -> assertion that (gate_hi & gate_lo)==0, and that every hi<->lo swap has at least DT_CYCLES cycles with both gates 0.
